act_issue_queue: RTL and testbench
==================================

// Module: act_issue_queue
// PURPOSE
//  Upstream feeder of the tFAW ActivationWindow checker.
//  Buffers activate commands (bank,row) from the scheduler and drives ACTREQ to the checker.
//  Enforces tRRD spacing between consecutive ACTs.
//  Each ACT is issued on the DRAM command port only in a cycle where ACTOK grants it.
// PARAMETERS
//  DEPTH   8   queue entries; power of 2, >=2
//  BANK_W  3   bank address width
//  ROW_W   16  row address width
//  TRRD    4   min cycles between issued ACTs (>=1; 1 = back-to-back allowed)
// PORTS
//  Clock      in   1       sole clock, posedge
//  Reset      in   1       asynchronous, active-low
//  in_valid   in   1       scheduler offers an ACT
//  in_ready   out  1       queue accepts; push = in_valid & in_ready
//  in_bank    in   BANK_W  bank of offered ACT
//  in_row     in   ROW_W   row of offered ACT
//  ACTREQ     out  1       request to ActivationWindow
//  ACTOK      in   1       same-cycle grant from ActivationWindow
//  act_valid  out  1       ACT command strobe to DRAM command bus (registered)
//  act_bank   out  BANK_W  bank of issued ACT
//  act_row    out  ROW_W   row of issued ACT
//  q_count    out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (Reset=0, async):
//   - q_count=0; ACTREQ=0; act_valid=0; act_bank=0; act_row=0.
//   - in_ready=0 while Reset=0.
//   - FSM to IDLE; tRRD counter=0; queue contents discarded.
//   - Mid-operation reset drops pending entries; no ACT is issued in the cycle Reset rises.
//  Queue:
//   - FIFO; rd/wr pointers carry an extra wrap bit.
//   - full = (q_count==DEPTH); empty = (q_count==0).
//   - in_ready = !full; there is no pass-through when full, even if a pop occurs that cycle.
//   - Push and pop in the same cycle: both take effect, q_count unchanged, order preserved.
//   - Push while empty: entry is visible at the head the next cycle (ACTREQ earliest 1 cycle after push).
//  Issue rule:
//   - issue = ACTREQ & ACTOK sampled at posedge.
//   - On issue: pop head; next cycle act_valid=1 with act_bank/act_row = popped entry (latency 1).
//   - Otherwise act_valid=0; act_bank/act_row hold their last values.
//   - ACTREQ is registered-state driven, never a combinational function of ACTOK (no loop).
//   - ACTREQ held with head stable until granted; head never changes while ACTREQ=1.
//  FSM (ACTREQ=1 only in REQ):
//   - IDLE:    !empty -> REQ
//   - REQ:     issue & TRRD>1 -> HOLD (trrd_cnt<=TRRD-1)
//              issue & TRRD==1 -> REQ if q_count>1 else IDLE
//              no issue -> REQ
//   - HOLD:    trrd_cnt decrements each cycle;
//              at trrd_cnt==1 -> REQ if (q_count>0 after this cycle's push) else IDLE
//  Arithmetic:
//   - trrd_cnt width $clog2(TRRD+1); never underflows (saturates at 0).
//   - q_count is exact 0..DEPTH.
//  ACTOK when ACTREQ=0: ignored.
//  Spacing: successive act_valid pulses are >=TRRD cycles apart.
// STRUCTURE
//  Package act_pkg:
//   - typedef struct packed {logic[BANK_W-1:0] bank; logic[ROW_W-1:0] row;} act_cmd_t
//   - typedef enum logic[1:0] {IDLE,REQ,HOLD} act_state_t
//   - default DEPTH/TRRD localparams.
//  Sub-module act_fifo: generic DEPTH x act_cmd_t FIFO exposing full/empty/count.
//  Top (act_issue_queue) holds FSM, tRRD counter, output register.
// TESTING (golden model in bench; checker ACTOK modelled or real ActivationWindow)
//  1 Reset then idle, in_valid=0 -> ACTREQ=0, act_valid=0, q_count=0, in_ready=1 for 20 cycles.
//  2 Push 1 ACT (bank 2,row 0x1234), ACTOK tied 1 -> ACTREQ high cycle+1;
//    act_valid pulse cycle+2 with bank 2, row 0x1234.
//  3 Push 4 ACTs back-to-back, ACTOK=1, TRRD=4 -> act_valid pulses exactly 4 cycles apart,
//    in FIFO order.
//  4 Fill 8 entries with ACTOK=0 -> q_count=8, in_ready=0, ACTREQ stays 1, head stable;
//    push attempt dropped; raise ACTOK -> drain in order.
//  5 At q_count=3, push and issue in the same cycle -> q_count stays 3; next act_valid
//    carries the old head.
//  6 Assert Reset low while in HOLD with 5 queued -> outputs 0 immediately (async);
//    after release q_count=0, no act_valid.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and default sizing for the ACT issue path in front of the tFAW checker.
package act_pkg;
  localparam int ACT_DEPTH  = 8;
  localparam int ACT_TRRD   = 4;
  localparam int ACT_BANK_W = 3;
  localparam int ACT_ROW_W  = 16;

  typedef struct packed {
    logic [ACT_BANK_W-1:0] bank;
    logic [ACT_ROW_W-1:0]  row;
  } act_cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} act_state_t;
endpackage

// File: rtl/act_fifo.sv
// Generic DEPTH-entry FIFO; pointers carry a wrap bit so count is exact 0..DEPTH.
module act_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage is not reset; a pointer reset is enough to discard contents.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/act_issue_queue.sv
// Buffers scheduler ACTs, requests the tFAW checker, and issues granted ACTs with tRRD spacing.
module act_issue_queue
  import act_pkg::*;
#(
  parameter int DEPTH  = ACT_DEPTH,
  parameter int BANK_W = ACT_BANK_W,
  parameter int ROW_W  = ACT_ROW_W,
  parameter int TRRD   = ACT_TRRD
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BANK_W-1:0]         in_bank,
  input  logic [ROW_W-1:0]          in_row,
  output logic                      ACTREQ,
  input  logic                      ACTOK,
  output logic                      act_valid,
  output logic [BANK_W-1:0]         act_bank,
  output logic [ROW_W-1:0]          act_row,
  output logic [$clog2(DEPTH):0]    q_count
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TW    = $clog2(TRRD + 1);
  localparam int CMD_W = BANK_W + ROW_W;

  act_state_t       state;
  logic [TW-1:0]    trrd_cnt;
  logic [CMD_W-1:0] head;
  logic             full, empty, push, issue;
  logic [CW-1:0]    count_nxt;

  assign in_ready  = Reset & ~full;
  assign push      = in_valid & in_ready;
  assign issue     = ACTREQ & ACTOK;
  assign count_nxt = q_count + CW'(push) - CW'(issue);

  act_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .din   ({in_bank, in_row}),
    .pop   (issue),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // ACTREQ is a flop updated with the state, so the grant never loops back into it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ACTREQ    <= 1'b0;
      trrd_cnt  <= '0;
      act_valid <= 1'b0;
      act_bank  <= '0;
      act_row   <= '0;
    end else begin
      act_valid <= issue;
      if (issue) {act_bank, act_row} <= head;
      case (state)
        IDLE: begin
          if (push || !empty) begin
            state  <= REQ;
            ACTREQ <= 1'b1;
          end
        end
        REQ: begin
          if (issue) begin
            if (TRRD > 1) begin
              state    <= HOLD;
              ACTREQ   <= 1'b0;
              trrd_cnt <= TW'(TRRD - 1);
            end else begin
              state  <= (count_nxt != '0) ? REQ : IDLE;
              ACTREQ <= (count_nxt != '0);
            end
          end
        end
        HOLD: begin
          if (trrd_cnt != '0) trrd_cnt <= trrd_cnt - TW'(1);
          if (trrd_cnt <= TW'(1)) begin
            state  <= (count_nxt != '0) ? REQ : IDLE;
            ACTREQ <= (count_nxt != '0);
          end
        end
        default: begin
          state  <= IDLE;
          ACTREQ <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_act_issue_queue.sv
// Directed bench for act_issue_queue: vector table for single/back-to-back issue plus corner sequences.
module tb_act_issue_queue;
  import act_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_bank = '0;
  logic [15:0] in_row = '0;
  logic        ACTREQ;
  logic        ACTOK = 1'b0;
  logic        act_valid;
  logic [2:0]  act_bank;
  logic [15:0] act_row;
  logic [3:0]  q_count;

  int nvec = 0;
  int nerr = 0;

  act_issue_queue dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bank   (in_bank),
    .in_row    (in_row),
    .ACTREQ    (ACTREQ),
    .ACTOK     (ACTOK),
    .act_valid (act_valid),
    .act_bank  (act_bank),
    .act_row   (act_row),
    .q_count   (q_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        iv;
    logic [2:0]  bank;
    logic [15:0] row;
    logic        ok;
    logic        e_req;
    logic        e_av;
    logic [2:0]  e_bank;
    logic [15:0] e_row;
    int          e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t     tv[$];
  act_cmd_t exp_q[$];

  function automatic vec_t mk(input logic iv, input logic [2:0] b, input logic [15:0] r,
                              input logic ok, input logic req, input logic av,
                              input logic [2:0] eb, input logic [15:0] er,
                              input int cnt, input logic rdy);
    vec_t v;
    v.iv = iv; v.bank = b; v.row = r; v.ok = ok;
    v.e_req = req; v.e_av = av; v.e_bank = eb; v.e_row = er; v.e_cnt = cnt; v.e_rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Grants every request; checks order against exp_q and exact tRRD spacing of pulses.
  task automatic drain(input int n, input string tag);
    int got = 0;
    int last = -1;
    act_cmd_t e;
    ACTOK = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      if (act_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("%s_bank%0d", tag, got), 32'(act_bank), 32'(e.bank));
          chk($sformatf("%s_row%0d", tag, got), 32'(act_row), 32'(e.row));
        end
        if (last >= 0) chk($sformatf("%s_spacing%0d", tag, got), 32'(c - last), 32'd4);
        last = c;
        got++;
      end
    end
    chk({tag, "_pulses"}, 32'(got), 32'(n));
    chk({tag, "_count_end"}, 32'(q_count), 32'd0);
  endtask

  initial begin
    // Test 1: reset values, then idle with grants offered that must be ignored
    #2 Reset = 1'b0;
    #1;
    chk("rst_actreq", 32'(ACTREQ), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("rst_av", 32'(act_valid), 32'd0);
    chk("rst_bank", 32'(act_bank), 32'd0);
    chk("rst_row", 32'(act_row), 32'd0);
    chk("rst_cnt", 32'(q_count), 32'd0);
    chk("rst_ready2", 32'(in_ready), 32'd0);
    Reset = 1'b1;
    ACTOK = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle_req%0d", i), 32'(ACTREQ), 32'd0);
      chk($sformatf("idle_av%0d", i), 32'(act_valid), 32'd0);
      chk($sformatf("idle_cnt%0d", i), 32'(q_count), 32'd0);
      chk($sformatf("idle_rdy%0d", i), 32'(in_ready), 32'd1);
    end

    // Test 2: single ACT; Test 3: four back-to-back pushes, pulses 4 cycles apart
    tv.push_back(mk(1, 2, 16'h1234, 1, 1, 0, 0, 0,          1, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 1, 2, 16'h1234,   0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(1, 1, 16'h0101, 1, 1, 0, 0, 0,          1, 1));
    tv.push_back(mk(1, 3, 16'h0202, 1, 0, 1, 1, 16'h0101,   1, 1));
    tv.push_back(mk(1, 5, 16'h0303, 1, 0, 0, 0, 0,          2, 1));
    tv.push_back(mk(1, 7, 16'h0404, 1, 0, 0, 0, 0,          3, 1));
    tv.push_back(mk(0, 0, 0,        1, 1, 0, 0, 0,          3, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 1, 3, 16'h0202,   2, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          2, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          2, 1));
    tv.push_back(mk(0, 0, 0,        1, 1, 0, 0, 0,          2, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 1, 5, 16'h0303,   1, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          1, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          1, 1));
    tv.push_back(mk(0, 0, 0,        1, 1, 0, 0, 0,          1, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 1, 7, 16'h0404,   0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    tv.push_back(mk(0, 0, 0,        1, 0, 0, 0, 0,          0, 1));
    foreach (tv[i]) begin
      in_valid = tv[i].iv;
      in_bank  = tv[i].bank;
      in_row   = tv[i].row;
      ACTOK    = tv[i].ok;
      tick();
      chk($sformatf("v%0d_req", i), 32'(ACTREQ), 32'(tv[i].e_req));
      chk($sformatf("v%0d_av", i), 32'(act_valid), 32'(tv[i].e_av));
      chk($sformatf("v%0d_cnt", i), 32'(q_count), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tv[i].e_rdy));
      if (tv[i].e_av) begin
        chk($sformatf("v%0d_bank", i), 32'(act_bank), 32'(tv[i].e_bank));
        chk($sformatf("v%0d_row", i), 32'(act_row), 32'(tv[i].e_row));
      end
    end
    in_valid = 1'b0;

    // Test 4: fill to DEPTH without grants, extra push dropped, then drain in order
    ACTOK = 1'b0;
    for (int i = 0; i < 8; i++) begin
      act_cmd_t c;
      c.bank = 3'(i);
      c.row  = 16'h1000 + 16'(i);
      in_valid = 1'b1; in_bank = c.bank; in_row = c.row;
      exp_q.push_back(c);
      tick();
      chk($sformatf("fill_cnt%0d", i), 32'(q_count), 32'(i + 1));
      chk($sformatf("fill_req%0d", i), 32'(ACTREQ), 32'd1);
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    in_bank = 3'd6; in_row = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("full_cnt%0d", i), 32'(q_count), 32'd8);
      chk($sformatf("full_req%0d", i), 32'(ACTREQ), 32'd1);
      chk($sformatf("full_av%0d", i), 32'(act_valid), 32'd0);
    end
    drain(8, "fill");
    for (int i = 0; i < 4; i++) tick();

    // Test 5: push and issue in the same cycle at q_count=3
    ACTOK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_cmd_t c;
      c.bank = 3'(i + 4);
      c.row  = 16'hA000 + 16'(i);
      in_valid = 1'b1; in_bank = c.bank; in_row = c.row;
      exp_q.push_back(c);
      tick();
    end
    chk("pp_cnt_before", 32'(q_count), 32'd3);
    in_valid = 1'b1; in_bank = 3'd3; in_row = 16'hA0FF;
    ACTOK = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_cnt", 32'(q_count), 32'd3);
    chk("pp_av", 32'(act_valid), 32'd1);
    chk("pp_bank", 32'(act_bank), 32'd4);
    chk("pp_row", 32'(act_row), 32'hA000);
    void'(exp_q.pop_front());
    begin
      act_cmd_t c;
      c.bank = 3'd3;
      c.row  = 16'hA0FF;
      exp_q.push_back(c);
    end
    drain(3, "pp");
    for (int i = 0; i < 4; i++) tick();

    // Test 6: async reset while in HOLD with 5 entries queued
    ACTOK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_bank = 3'(i + 1); in_row = 16'h2000 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    ACTOK = 1'b1;
    tick();
    ACTOK = 1'b0;
    chk("hold_av", 32'(act_valid), 32'd1);
    chk("hold_cnt", 32'(q_count), 32'd5);
    #2 Reset = 1'b0;
    #1;
    chk("arst_av", 32'(act_valid), 32'd0);
    chk("arst_bank", 32'(act_bank), 32'd0);
    chk("arst_row", 32'(act_row), 32'd0);
    chk("arst_req", 32'(ACTREQ), 32'd0);
    chk("arst_cnt", 32'(q_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    Reset = 1'b1;
    ACTOK = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_av%0d", i), 32'(act_valid), 32'd0);
      chk($sformatf("post_cnt%0d", i), 32'(q_count), 32'd0);
      chk($sformatf("post_req%0d", i), 32'(ACTREQ), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
